mouse_rx_framer: RTL and testbench

MOUSE_RX_FRAMER -- requirements
Module: mouse_rx_framer

---
 rtl/mouse_pkg.sv | 23 ++
 rtl/ps2_edge_sync.sv | 40 ++++
 rtl/mouse_rx_framer.sv | 155 +++++++++++++++
 tb/tb_mouse_rx_framer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// -----------------------------------------------------------------------------
// mouse_pkg
// Shared definitions for the PS/2 mouse receive framer:
//   state_t                 - framer FSM states
//   DEFAULT_TIMEOUT_CYCLES  - default inter-edge timeout (1 ms at 100 MHz)
//   ERR_PARITY_BIT          - BYTE_ERROR index of the parity error flag
//   ERR_FRAMING_BIT         - BYTE_ERROR index of the framing (stop bit) flag
// -----------------------------------------------------------------------------
package mouse_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

   localparam int ERR_PARITY_BIT  = 0;
   localparam int ERR_FRAMING_BIT = 1;

endpackage

// File: rtl/ps2_edge_sync.sv
// -----------------------------------------------------------------------------
// ps2_edge_sync
// Two-flop synchroniser for one raw PS/2 pad line plus a falling-edge detector.
// All flops reset to 1 (the idle level of an open-collector PS/2 line), so a
// reset never manufactures a spurious falling edge.
// Ports:
//   clk   - system clock
//   srst  - synchronous active-high reset
//   raw   - asynchronous pad input
//   sync  - synchronised copy of raw
//   fall  - high for the cycle where sync is 0 and its previous value was 1
// -----------------------------------------------------------------------------
module ps2_edge_sync (
   input  logic clk,
   input  logic srst,
   input  logic raw,
   output logic sync,
   output logic fall
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         meta_reg <= 1'b1;
         sync_reg <= 1'b1;
         prev_reg <= 1'b1;
      end else begin
         meta_reg <= raw;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   assign sync = sync_reg;
   assign fall = prev_reg & ~sync_reg;

endmodule

// File: rtl/mouse_rx_framer.sv
// -----------------------------------------------------------------------------
// mouse_rx_framer
// Receives 11-bit PS/2 device-to-host frames (start, 8 data LSB first, odd
// parity, stop) and presents each byte with its error flags.
// Ports:
//   CLK           - system clock, rising edge
//   RESET         - synchronous active-high reset
//   CLK_MOUSE_IN  - raw PS/2 clock from the pad (asynchronous)
//   DATA_MOUSE_IN - raw PS/2 data from the pad (asynchronous)
//   READ_ENABLE   - receiver armed; low while the host is transmitting
//   BYTE_READY    - one-cycle pulse, BYTE_DATA/BYTE_ERROR valid
//   BYTE_DATA     - last received byte (held between frames)
//   BYTE_ERROR    - [0] parity error, [1] framing error (held between frames)
//   FRAME_TIMEOUT - one-cycle pulse, frame abandoned after a stalled PS/2 clock
//   BUSY          - framer is inside a frame
// -----------------------------------------------------------------------------
module mouse_rx_framer
   import mouse_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLK_MOUSE_IN,
   input  logic       DATA_MOUSE_IN,
   input  logic       READ_ENABLE,
   output logic       BYTE_READY,
   output logic [7:0] BYTE_DATA,
   output logic [1:0] BYTE_ERROR,
   output logic       FRAME_TIMEOUT,
   output logic       BUSY
);

   // Wide enough to hold TIMEOUT_CYCLES-1, the terminal count.
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic ps2_clk_sync;
   logic ps2_clk_fall;
   logic ps2_data_sync;
   logic data_fall_unused;

   ps2_edge_sync u_clk_sync (
      .clk  (CLK),
      .srst (RESET),
      .raw  (CLK_MOUSE_IN),
      .sync (ps2_clk_sync),
      .fall (ps2_clk_fall)
   );

   ps2_edge_sync u_data_sync (
      .clk  (CLK),
      .srst (RESET),
      .raw  (DATA_MOUSE_IN),
      .sync (ps2_data_sync),
      .fall (data_fall_unused)
   );

   state_t          state_reg,         state_next;
   logic [2:0]      bit_cnt_reg,       bit_cnt_next;
   logic [7:0]      shift_reg,         shift_next;
   logic            parity_reg,        parity_next;
   logic [CW-1:0]   edge_cnt_reg,      edge_cnt_next;
   logic            byte_ready_reg,    byte_ready_next;
   logic            frame_timeout_reg, frame_timeout_next;
   logic [7:0]      byte_data_reg,     byte_data_next;
   logic [1:0]      byte_error_reg,    byte_error_next;

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg         <= IDLE;
         bit_cnt_reg       <= '0;
         shift_reg         <= '0;
         parity_reg        <= 1'b0;
         edge_cnt_reg      <= '0;
         byte_ready_reg    <= 1'b0;
         frame_timeout_reg <= 1'b0;
         byte_data_reg     <= '0;
         byte_error_reg    <= '0;
      end else begin
         state_reg         <= state_next;
         bit_cnt_reg       <= bit_cnt_next;
         shift_reg         <= shift_next;
         parity_reg        <= parity_next;
         edge_cnt_reg      <= edge_cnt_next;
         byte_ready_reg    <= byte_ready_next;
         frame_timeout_reg <= frame_timeout_next;
         byte_data_reg     <= byte_data_next;
         byte_error_reg    <= byte_error_next;
      end
   end

   // Next-state logic. Inside a frame the priority is: receiver disarmed,
   // then a PS/2 falling edge, then the timeout, so an edge landing on the
   // terminal count still advances the frame.
   always_comb begin
      state_next         = state_reg;
      bit_cnt_next       = bit_cnt_reg;
      shift_next         = shift_reg;
      parity_next        = parity_reg;
      edge_cnt_next      = '0;
      byte_ready_next    = 1'b0;
      frame_timeout_next = 1'b0;
      byte_data_next     = byte_data_reg;
      byte_error_next    = byte_error_reg;

      if (state_reg == IDLE) begin
         if (ps2_clk_fall && READ_ENABLE && !ps2_data_sync) begin
            state_next   = DATA;
            bit_cnt_next = '0;
         end
      end else if (!READ_ENABLE) begin
         state_next = IDLE;
      end else if (ps2_clk_fall) begin
         unique case (state_reg)
            DATA: begin
               shift_next[bit_cnt_reg] = ps2_data_sync;
               bit_cnt_next            = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  state_next = PARITY;
               end
            end
            PARITY: begin
               parity_next = ps2_data_sync;
               state_next  = STOP;
            end
            STOP: begin
               state_next      = IDLE;
               byte_ready_next = 1'b1;
               byte_data_next  = shift_reg;
               // Odd parity: data bits plus parity bit must XOR to 1.
               byte_error_next[ERR_PARITY_BIT]  = ~(^shift_reg ^ parity_reg);
               byte_error_next[ERR_FRAMING_BIT] = ~ps2_data_sync;
            end
            default: state_next = IDLE;
         endcase
      end else if (edge_cnt_reg == CNT_LAST) begin
         state_next         = IDLE;
         frame_timeout_next = 1'b1;
      end else begin
         edge_cnt_next = edge_cnt_reg + CW'(1);
      end
   end

   // Outputs
   always_comb begin
      BUSY          = (state_reg != IDLE);
      BYTE_READY    = byte_ready_reg;
      FRAME_TIMEOUT = frame_timeout_reg;
      BYTE_DATA     = byte_data_reg;
      BYTE_ERROR    = byte_error_reg;
   end

endmodule

// File: tb/tb_mouse_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_mouse_rx_framer
// Directed bench for mouse_rx_framer. Each transmitted frame that should be
// received pushes its expected byte/error pair to a scoreboard queue; a
// monitor pops and compares whenever BYTE_READY pulses.
// -----------------------------------------------------------------------------
module tb_mouse_rx_framer;

   localparam int TO   = 200;   // small timeout keeps the run short
   localparam int HALF = 10;    // PS/2 half-period in system clocks

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] err;
   } exp_t;

   logic       CLK           = 1'b0;
   logic       RESET         = 1'b1;
   logic       CLK_MOUSE_IN  = 1'b1;
   logic       DATA_MOUSE_IN = 1'b1;
   logic       READ_ENABLE   = 1'b1;
   logic       BYTE_READY;
   logic [7:0] BYTE_DATA;
   logic [1:0] BYTE_ERROR;
   logic       FRAME_TIMEOUT;
   logic       BUSY;

   int   vectors        = 0;
   int   miscompares    = 0;
   int   timeout_pulses = 0;
   exp_t sb[$];
   exp_t mon_exp;

   mouse_rx_framer #(.TIMEOUT_CYCLES(TO)) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .CLK_MOUSE_IN  (CLK_MOUSE_IN),
      .DATA_MOUSE_IN (DATA_MOUSE_IN),
      .READ_ENABLE   (READ_ENABLE),
      .BYTE_READY    (BYTE_READY),
      .BYTE_DATA     (BYTE_DATA),
      .BYTE_ERROR    (BYTE_ERROR),
      .FRAME_TIMEOUT (FRAME_TIMEOUT),
      .BUSY          (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Monitor: scoreboard compare on every BYTE_READY, count timeout pulses.
   always @(negedge CLK) begin
      if (FRAME_TIMEOUT === 1'b1) timeout_pulses++;
      if (BYTE_READY === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_byte_ready", 32'(BYTE_READY), 32'd0);
         end else begin
            mon_exp = sb.pop_front();
            check("byte_data", 32'(BYTE_DATA), 32'(mon_exp.data));
            check("byte_error", 32'(BYTE_ERROR), 32'(mon_exp.err));
            $display("rx byte 0x%02h err %02b", BYTE_DATA, BYTE_ERROR);
         end
      end
   end

   // One PS/2 bit: data set up, clock low for HALF, clock high for HALF.
   // With chk set, BYTE_READY latency after this falling edge is checked.
   task automatic ps2_bit(input logic b, input bit chk);
      DATA_MOUSE_IN = b;
      repeat (HALF) @(negedge CLK);
      CLK_MOUSE_IN = 1'b0;
      if (chk) begin
         @(posedge CLK);
         @(posedge CLK);
         #1 check("ready_not_before_detect", 32'(BYTE_READY), 32'd0);
         @(posedge CLK);
         #1 check("ready_one_cycle_after_detect", 32'(BYTE_READY), 32'd1);
         repeat (HALF - 2) @(negedge CLK);
      end else begin
         repeat (HALF) @(negedge CLK);
      end
      CLK_MOUSE_IN = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                             input bit expect_it, input bit chk);
      exp_t e;
      if (expect_it) begin
         e.data = d;
         e.err  = {~s, ~(^d ^ p)};
         sb.push_back(e);
      end
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
      ps2_bit(p, 1'b0);
      ps2_bit(s, chk);
      DATA_MOUSE_IN = 1'b1;
   endtask

   initial begin
      int to_before;

      // Reset values
      RESET = 1'b1;
      repeat (4) @(negedge CLK);
      check("rst_byte_ready", 32'(BYTE_READY), 32'd0);
      check("rst_byte_data", 32'(BYTE_DATA), 32'd0);
      check("rst_byte_error", 32'(BYTE_ERROR), 32'd0);
      check("rst_frame_timeout", 32'(FRAME_TIMEOUT), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      RESET = 1'b0;
      repeat (5) @(negedge CLK);

      // Clean 0xFA with latency check, then data holds between frames
      send_frame(8'hFA, 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (5) @(negedge CLK);
      check("fa_drained", 32'(sb.size()), 32'd0);
      check("fa_busy_idle", 32'(BUSY), 32'd0);
      repeat (30) @(negedge CLK);
      check("fa_data_held", 32'(BYTE_DATA), 32'hFA);
      check("fa_error_held", 32'(BYTE_ERROR), 32'd0);

      // A falling edge with data high in IDLE is not a start bit
      ps2_bit(1'b1, 1'b0);
      repeat (3) @(negedge CLK);
      check("idle_edge_ignored", 32'(BUSY), 32'd0);

      // Parity error, then framing error
      send_frame(8'h08, 1'b1, 1'b1, 1'b1, 1'b0);
      send_frame(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (5) @(negedge CLK);
      check("err_frames_drained", 32'(sb.size()), 32'd0);

      // Stalled clock after four data bits
      to_before = timeout_pulses;
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(i[0], 1'b0);
      repeat (3) @(negedge CLK);
      check("busy_mid_frame", 32'(BUSY), 32'd1);
      repeat (TO + 20) @(negedge CLK);
      check("timeout_pulse_count", 32'(timeout_pulses - to_before), 32'd1);
      check("busy_after_timeout", 32'(BUSY), 32'd0);
      $display("timeout frame aborted, pulses %0d", timeout_pulses - to_before);
      send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (5) @(negedge CLK);
      check("after_timeout_drained", 32'(sb.size()), 32'd0);

      // Receiver disarmed mid-frame, then a whole frame while disarmed
      to_before = timeout_pulses;
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(i[0], 1'b0);
      repeat (3) @(negedge CLK);
      check("busy_before_disarm", 32'(BUSY), 32'd1);
      READ_ENABLE = 1'b0;
      @(negedge CLK);
      check("busy_after_disarm", 32'(BUSY), 32'd0);
      send_frame(8'hAA, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (TO + 20) @(negedge CLK);
      check("disarmed_busy", 32'(BUSY), 32'd0);
      check("disarmed_no_timeout", 32'(timeout_pulses - to_before), 32'd0);
      READ_ENABLE = 1'b1;
      repeat (5) @(negedge CLK);

      // Back-to-back frames, then reset during a fourth
      send_frame(8'h08, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'h10, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b1, 1'b1, 1'b1, 1'b0);
      to_before = timeout_pulses;
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'b1, 1'b0);
      check("b2b_drained", 32'(sb.size()), 32'd0);
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      check("midrst_byte_ready", 32'(BYTE_READY), 32'd0);
      check("midrst_byte_data", 32'(BYTE_DATA), 32'd0);
      check("midrst_byte_error", 32'(BYTE_ERROR), 32'd0);
      check("midrst_frame_timeout", 32'(FRAME_TIMEOUT), 32'd0);
      check("midrst_busy", 32'(BUSY), 32'd0);
      RESET = 1'b0;
      repeat (TO + 20) @(negedge CLK);
      check("post_rst_no_timeout", 32'(timeout_pulses - to_before), 32'd0);
      check("post_rst_busy", 32'(BUSY), 32'd0);
      check("post_rst_data", 32'(BYTE_DATA), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
